alu181_serial: RTL and testbench

Parametrised, digit-serial successor to the 4-bit 74181-style ALU. It accepts WIDTH-bit operands with the same 16-function select, mode and active-low carry-in, and evaluates one DIGIT-bit slice per clock from LSB to MSB. The slice carry and the group generate/propagate terms are held in registers between cycles. It sits beside the datapath register file as a shared, multi-cycle arithmetic/logic unit with a start/busy/done handshake.

---
 rtl/alu181_serial_if.sv | 48 ++++
 rtl/alu181_serial.sv | 209 ++++++++++++++++++++
 tb/tb_alu181_serial.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/alu181_serial_if.sv
// ---------------------------------------------------------------------------
// alu181_serial_if
//
// Purpose : bundles the request and result signals of the digit-serial
//           74181-style ALU so that a requester and the ALU share one port.
//
// Signals :
//   start                 request; the ALU samples it only while busy=0
//   a, b     [WIDTH-1:0]  operands
//   s        [3:0]        74181 function select
//   m                     1 = logic, 0 = arithmetic
//   cn_n                  active-low carry-in (0 means a carry of 1)
//   f        [WIDTH-1:0]  result
//   eq                    result is all ones (74181 A=B output)
//   g_n, p_n              active-low group generate / propagate
//   cn_out_n              active-low carry-out of the MSB
//   busy                  operation in progress
//   done                  one-cycle pulse when the results are valid
//
// Modports: master = requester, slave = ALU.
// ---------------------------------------------------------------------------
interface alu181_serial_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       s;
    logic             m;
    logic             cn_n;
    logic [WIDTH-1:0] f;
    logic             eq;
    logic             g_n;
    logic             p_n;
    logic             cn_out_n;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, s, m, cn_n,
        input  f, eq, g_n, p_n, cn_out_n, busy, done
    );

    modport slave (
        input  start, a, b, s, m, cn_n,
        output f, eq, g_n, p_n, cn_out_n, busy, done
    );
endinterface

// File: rtl/alu181_serial.sv
// ---------------------------------------------------------------------------
// alu181_serial
//
// Purpose : digit-serial successor to the 4-bit 74181 ALU. The operands are
//           WIDTH bits wide. One DIGIT-bit slice is evaluated per clock, from
//           the LSB to the MSB, so one operation takes NDIG = WIDTH/DIGIT
//           cycles. The slice carry and the running group generate/propagate
//           terms are held in registers between cycles.
//
// Ports   :
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu181_serial_if.slave
//            in : start, a, b, s, m, cn_n (captured on an accepted start)
//            out: f, eq, g_n, p_n, cn_out_n, busy, done (all registered)
//
// Behaviour:
//   Per bit  X = a | (b & s[0]) | (~b & s[1])
//            Y = (a & ~b & s[2]) | (a & b & s[3])
//   m=0 : f = X + Y + ~cn_n, and cn_out_n = ~carry out of the MSB
//   m=1 : f = ~(X ^ Y), and cn_out_n = 1
//   p_n = ~&X. g_n = ~G, where G is the lookahead generate with
//   bit generate = Y and bit propagate = X.
//   eq  = &f.
//   f is written digit by digit while the unit runs. It is valid at done and
//   is held until the next accepted start. eq, g_n, p_n and cn_out_n change
//   only on the done edge or at reset.
// ---------------------------------------------------------------------------
module alu181_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    alu181_serial_if.slave   bus
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
    localparam logic [IDXW-1:0] IDX_ZERO = IDXW'(0);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // X term of one digit. In arithmetic mode it is the bit propagate.
    function automatic logic [DIGIT-1:0] x_bits(
        input logic [DIGIT-1:0] av,
        input logic [DIGIT-1:0] bv,
        input logic [3:0]       sel
    );
        return av | (bv & {DIGIT{sel[0]}}) | (~bv & {DIGIT{sel[1]}});
    endfunction

    // Y term of one digit. In arithmetic mode it is the bit generate.
    function automatic logic [DIGIT-1:0] y_bits(
        input logic [DIGIT-1:0] av,
        input logic [DIGIT-1:0] bv,
        input logic [3:0]       sel
    );
        return (av & ~bv & {DIGIT{sel[2]}}) | (av & bv & {DIGIT{sel[3]}});
    endfunction

    // Digit-level {generate, propagate}. A generate in a lower bit reaches
    // the digit boundary only if every higher bit of the digit propagates.
    function automatic logic [1:0] digit_gp(
        input logic [DIGIT-1:0] xv,
        input logic [DIGIT-1:0] yv
    );
        logic g;
        logic p;
        g = 1'b0;
        p = 1'b1;
        for (int i = 0; i < DIGIT; i++) begin
            g = yv[i] | (xv[i] & g);
            p = p & xv[i];
        end
        return {g, p};
    endfunction

    // Architectural state
    logic [0:0]       state_r;
    logic [IDXW-1:0]  idx_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [3:0]       s_r;
    logic             m_r;
    logic             carry_r;
    logic             g_acc_r;
    logic             p_acc_r;

    // Registered outputs
    logic [WIDTH-1:0] f_r;
    logic             eq_r;
    logic             g_n_r;
    logic             p_n_r;
    logic             cn_out_n_r;
    logic             busy_r;
    logic             done_r;

    // Slice datapath
    logic [DIGIT-1:0] a_dig_s;
    logic [DIGIT-1:0] b_dig_s;
    logic [DIGIT-1:0] x_dig_s;
    logic [DIGIT-1:0] y_dig_s;
    logic [DIGIT:0]   sum_s;
    logic [DIGIT-1:0] f_dig_s;
    logic             carry_next_s;
    logic [1:0]       gp_s;
    logic             g_next_s;
    logic             p_next_s;
    logic [WIDTH-1:0] f_merge_s;
    logic             last_s;

    // Evaluate the current digit and merge it into the running result.
    always_comb begin
        a_dig_s  = a_r[idx_r*DIGIT +: DIGIT];
        b_dig_s  = b_r[idx_r*DIGIT +: DIGIT];
        x_dig_s  = x_bits(a_dig_s, b_dig_s, s_r);
        y_dig_s  = y_bits(a_dig_s, b_dig_s, s_r);
        sum_s    = {1'b0, x_dig_s} + {1'b0, y_dig_s} + {{DIGIT{1'b0}}, carry_r};
        gp_s     = digit_gp(x_dig_s, y_dig_s);
        g_next_s = gp_s[1] | (gp_s[0] & g_acc_r);
        p_next_s = p_acc_r & gp_s[0];
        if (m_r) begin
            // Logic mode has no carry chain, so the carry is left untouched.
            f_dig_s      = ~(x_dig_s ^ y_dig_s);
            carry_next_s = carry_r;
        end else begin
            f_dig_s      = sum_s[DIGIT-1:0];
            carry_next_s = sum_s[DIGIT];
        end
        f_merge_s = f_r;
        f_merge_s[idx_r*DIGIT +: DIGIT] = f_dig_s;
        last_s    = (idx_r == LAST_IDX);
    end

    // Control FSM: capture on start, then one digit per cycle, then publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            idx_r      <= IDX_ZERO;
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            s_r        <= 4'b0000;
            m_r        <= 1'b0;
            carry_r    <= 1'b0;
            g_acc_r    <= 1'b0;
            p_acc_r    <= 1'b1;
            f_r        <= {WIDTH{1'b0}};
            eq_r       <= 1'b0;
            g_n_r      <= 1'b1;
            p_n_r      <= 1'b1;
            cn_out_n_r <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        a_r     <= bus.a;
                        b_r     <= bus.b;
                        s_r     <= bus.s;
                        m_r     <= bus.m;
                        carry_r <= ~bus.cn_n;
                        g_acc_r <= 1'b0;
                        p_acc_r <= 1'b1;
                        idx_r   <= IDX_ZERO;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    f_r     <= f_merge_s;
                    carry_r <= carry_next_s;
                    g_acc_r <= g_next_s;
                    p_acc_r <= p_next_s;
                    idx_r   <= idx_r + IDX_ONE;
                    if (last_s) begin
                        cn_out_n_r <= m_r ? 1'b1 : ~carry_next_s;
                        g_n_r      <= ~g_next_s;
                        p_n_r      <= ~p_next_s;
                        eq_r       <= &f_merge_s;
                        done_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        idx_r      <= IDX_ZERO;
                        state_r    <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    idx_r   <= IDX_ZERO;
                end
            endcase
        end
    end

    assign bus.f        = f_r;
    assign bus.eq       = eq_r;
    assign bus.g_n      = g_n_r;
    assign bus.p_n      = p_n_r;
    assign bus.cn_out_n = cn_out_n_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;

endmodule

// File: tb/tb_alu181_serial.sv
// ---------------------------------------------------------------------------
// tb_alu181_serial
//
// Directed vectors with hand-computed results. Issuing an operation pushes
// its expected response and the expected done cycle into a scoreboard queue.
// A separate monitor pops the queue and compares whenever done is high.
// ---------------------------------------------------------------------------
module tb_alu181_serial;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alu181_serial_if #(.WIDTH(WIDTH)) bus ();

    alu181_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string            name;
        logic [WIDTH-1:0] f;
        logic             eq;
        logic             g_n;
        logic             p_n;
        logic             cn_out_n;
        int               cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d want no done", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk({mon_e.name, ".f"},        32'(bus.f),        32'(mon_e.f));
                chk({mon_e.name, ".eq"},       32'(bus.eq),       32'(mon_e.eq));
                chk({mon_e.name, ".g_n"},      32'(bus.g_n),      32'(mon_e.g_n));
                chk({mon_e.name, ".p_n"},      32'(bus.p_n),      32'(mon_e.p_n));
                chk({mon_e.name, ".cn_out_n"}, 32'(bus.cn_out_n), 32'(mon_e.cn_out_n));
                chk({mon_e.name, ".latency"},  32'(cyc),          32'(mon_e.cyc));
                chk({mon_e.name, ".busy_at_done"}, 32'(bus.busy), 32'd0);
            end
        end
    end

    // Called at a falling edge. Drives one start pulse across the next rising
    // edge and optionally queues the expected response.
    task automatic issue(input string name,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] s, input logic m, input logic cn_n,
                         input logic [15:0] ef, input logic eeq, input logic eg,
                         input logic ep, input logic eco, input bit push);
        exp_t e;
        bus.a     = a;
        bus.b     = b;
        bus.s     = s;
        bus.m     = m;
        bus.cn_n  = cn_n;
        bus.start = 1'b1;
        if (push) begin
            e.name     = name;
            e.f        = ef;
            e.eq       = eeq;
            e.g_n      = eg;
            e.p_n      = ep;
            e.cn_out_n = eco;
            e.cyc      = cyc + 1 + NDIG;
            sb_q.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk({name, ".busy"}, 32'(bus.busy), 32'd1);
    endtask

    // Waits, with a bound, until every queued result has been seen.
    task automatic drain(input string name);
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s.timeout: got %0d results outstanding want 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic chk_reset_values(input string name);
        chk({name, ".f"},        32'(bus.f),        32'h0);
        chk({name, ".eq"},       32'(bus.eq),       32'd0);
        chk({name, ".g_n"},      32'(bus.g_n),      32'd1);
        chk({name, ".p_n"},      32'(bus.p_n),      32'd1);
        chk({name, ".cn_out_n"}, 32'(bus.cn_out_n), 32'd1);
        chk({name, ".busy"},     32'(bus.busy),     32'd0);
        chk({name, ".done"},     32'(bus.done),     32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.a     = 16'h0000;
        bus.b     = 16'h0000;
        bus.s     = 4'b0000;
        bus.m     = 1'b0;
        bus.cn_n  = 1'b1;
        rst_n     = 1'b1;

        // Asynchronous reset before the first rising edge
        #2 rst_n = 1'b0;
        #1 chk_reset_values("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        //      name       a         b         s        m     cn_n  f         eq    g_n   p_n   cn_out_n
        issue("add",      16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, 16'h2233, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        drain("add");
        issue("ripple",   16'hFFFF, 16'h0000, 4'b1001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        drain("ripple");
        issue("sub_cin1", 16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        drain("sub_cin1");
        issue("sub_cin0", 16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        drain("sub_cin0");
        issue("xor",      16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 16'h0FF0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        drain("xor");
        issue("ones",     16'hF0F0, 16'hFF00, 4'b1100, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        drain("ones");
        // MSB overflow: group generate set. eq must hold its old value mid-run.
        issue("ovf",      16'h8000, 16'h8000, 4'b1001, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("ovf.eq_held_mid_run", 32'(bus.eq), 32'd1);
        drain("ovf");

        // A start while busy must be ignored. The monitor flags any extra done.
        issue("ign_add",  16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, 16'h2233, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        bus.a     = 16'hFFFF;
        bus.b     = 16'hFFFF;
        bus.s     = 4'b1100;
        bus.m     = 1'b1;
        bus.cn_n  = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        drain("ign_add");
        repeat (6) @(negedge clk);

        // Back-to-back: the second start is issued in the done cycle.
        issue("b2b_first", 16'hFFFF, 16'h0000, 4'b1001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20 && bus.done !== 1'b1; i++) @(negedge clk);
        issue("b2b_second", 16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 16'h0FF0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        drain("b2b");

        // Reset while digit 2 is pending: the operation aborts with no done.
        issue("abort", 16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_values("abort_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort.no_done", 32'(bus.done), 32'd0);
        end
        issue("post_rst_add", 16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, 16'h2233, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        drain("post_rst_add");

        // The result is held after done while no new start arrives.
        repeat (3) @(negedge clk);
        chk("hold.f",    32'(bus.f),    32'h2233);
        chk("hold.busy", 32'(bus.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
